// File: rtl/agp32_acc_unit_if.sv
// Bundle of argument, result and control signals for agp32_acc_unit.
// Handshakes: a transfer happens on a posedge where valid && ready are both high.
// The producer holds its payload stable while valid is high and ready is low.
interface agp32_acc_unit_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic [DATA_W-1:0] arg;
    logic [1:0]        arg_mode;
    logic              arg_valid;
    logic              arg_ready;
    logic [DATA_W-1:0] res;
    logic              res_valid;
    logic              res_ready;
    logic              flush;
    logic [LVL_W-1:0]  level;
    logic              busy;
    logic [1:0]        dbg_state;

    modport slave (
        input  arg, arg_mode, arg_valid, res_ready, flush,
        output arg_ready, res, res_valid, level, busy, dbg_state
    );

    modport master (
        output arg, arg_mode, arg_valid, res_ready, flush,
        input  arg_ready, res, res_valid, level, busy, dbg_state
    );
endinterface

// File: rtl/agp32_acc_unit.sv
// Argument FIFO feeding a fixed-latency engine: half-word add, add with carry,
// popcount and byte reversal, with a held result register and synchronous flush.
module agp32_acc_unit #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    agp32_acc_unit_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int H  = DATA_W / 2;
    localparam int NB = DATA_W / 8;
    localparam int EW = DATA_W + 2;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COMPUTE = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    logic [EW-1:0]     r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [LW-1:0]     r_level;
    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_op;
    logic [1:0]        r_mode;
    logic [DATA_W-1:0] r_res;
    logic              r_res_valid;

    logic              w_full;
    logic              w_empty;
    logic              w_pop_req;
    logic              w_pop;
    logic              w_push;
    logic              w_arg_ready;
    logic [EW-1:0]     w_head;
    logic [H:0]        w_sum;
    logic [DATA_W-1:0] w_ones;
    logic [DATA_W-1:0] w_swap;
    logic [DATA_W-1:0] w_result;

    assign w_full  = (r_level == LW'(DEPTH));
    assign w_empty = (r_level == '0);
    assign w_head  = r_mem[r_rd_ptr];

    // A slot freed by this cycle's pop is offered to the producer in the same
    // cycle, so a full FIFO can swap one entry in and one out without loss.
    assign w_pop_req   = !w_empty &&
                         ((r_state == S_IDLE) ||
                          (r_state == S_DONE && r_res_valid && bus.res_ready));
    assign w_pop       = w_pop_req && !bus.flush;
    assign w_arg_ready = !w_full || w_pop_req;
    assign w_push      = bus.arg_valid && w_arg_ready && !bus.flush;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {bus.arg_mode, bus.arg};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else if (bus.flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    always_comb begin
        w_sum    = {1'b0, r_op[DATA_W-1:H]} + {1'b0, r_op[H-1:0]};
        w_ones   = '0;
        for (int i = 0; i < DATA_W; i++) begin
            w_ones = w_ones + DATA_W'(r_op[i]);
        end
        // Only whole bytes are mirrored; any leftover top bits keep their place.
        w_swap   = r_op;
        for (int b = 0; b < NB; b++) begin
            w_swap[b*8 +: 8] = r_op[(NB-1-b)*8 +: 8];
        end
        w_result = '0;
        case (r_mode)
            2'd0:    w_result = {{(DATA_W-H){1'b0}}, w_sum[H-1:0]};
            2'd1:    w_result = {{(DATA_W-H-1){1'b0}}, w_sum};
            2'd2:    w_result = w_ones;
            default: w_result = w_swap;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_op        <= '0;
            r_mode      <= '0;
            r_res       <= '0;
            r_res_valid <= 1'b0;
        end else if (bus.flush) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_res_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_op    <= w_head[DATA_W-1:0];
                        r_mode  <= w_head[EW-1:DATA_W];
                        r_cnt   <= CW'(LATENCY - 1);
                        r_state <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end else begin
                        r_res       <= w_result;
                        r_res_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (bus.res_ready) begin
                        r_res_valid <= 1'b0;
                        if (w_pop) begin
                            r_op    <= w_head[DATA_W-1:0];
                            r_mode  <= w_head[EW-1:DATA_W];
                            r_cnt   <= CW'(LATENCY - 1);
                            r_state <= S_COMPUTE;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_res_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.arg_ready = w_arg_ready;
    assign bus.res       = r_res;
    assign bus.res_valid = r_res_valid;
    assign bus.level     = r_level;
    assign bus.busy      = (r_state != S_IDLE) || !w_empty;
    assign bus.dbg_state = r_state;
endmodule
